cas_fetch: RTL and testbench
============================

Name: cas_fetch

Overview:
- Sequential byte prefetcher between the SDRAM CAS region (sdram port 2, toggle req/ack handshake) and the tape bit encoder.
- Walks the loaded CAS image from offset 0 to end_addr_i and selects the correct byte lane from the 16-bit SDRAM word.
- Buffers the bytes in a small FIFO and presents them as a valid/ready byte stream, so SDRAM latency never stalls tape bit timing.
- Handles rewind (including a rewind while a fetch is in flight) and end-of-tape.

Parameters:
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥2.
- BASE_ADDR, 26'h1800000, SDRAM byte address of CAS offset 0 (bits 24:23 = 2'b11).

Ports:
- clk_i  in  1  system clock (clk_sys).
- reset_n_i  in  1  asynchronous active-low reset.
- rewind_i  in  1  synchronous level: flush and restart at offset 0.
- loaded_i  in  1  a CAS image is present; 0 = no fetches, eof.
- end_addr_i  in  18  offset of last valid byte, inclusive.
- sdram_req_o  out  1  request toggle.
- sdram_ack_i  in  1  acknowledge toggle.
- sdram_addr_o  out  26  byte address = BASE_ADDR + fetch offset.
- sdram_ds_o  out  2  {~addr[0], addr[0]}.
- sdram_q_i  in  16  read word, valid in the cycle ack matches req.
- byte_o  out  8  FIFO head byte (show-ahead).
- byte_valid_o  out  1  FIFO non-empty.
- byte_ready_i  in  1  consumer pop; pop occurs when valid & ready.
- eof_o  out  1  all bytes through end_addr_i delivered and FIFO empty.
- fill_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- pos_o  out  18  offset of next byte to be popped (tape counter).

Behaviour:
- Async reset values:
  - sdram_req_o=0, fetch offset=0, pos_o=0.
  - FIFO empty: byte_valid_o=0, fill_o=0.
  - byte_o=0.
  - eof_o=!loaded_i (combinational on loaded_i).
  - FSM in IDLE.
- Handshake:
  - A request is outstanding while sdram_req_o != sdram_ack_i.
  - At most one request is outstanding at a time.
  - A request is issued by toggling sdram_req_o. sdram_addr_o and sdram_ds_o are registered and stay stable until the ack arrives.
- FSM states: IDLE, WAIT, DRAIN.
  - IDLE → WAIT when all of these hold: loaded_i=1, fetch offset ≤ end_addr_i, (fill_o + 0) < FIFO_DEPTH, rewind_i=0. On that edge: toggle req, latch address.
  - WAIT → IDLE when ack==req. On that edge:
    - push lane byte: addr[0]=0 → q[15:8]; addr[0]=1 → q[7:0].
    - fetch offset +1.
  - WAIT → DRAIN if rewind_i=1 while the request is outstanding.
  - DRAIN → IDLE when ack==req. The returned data is discarded.
- Slot reservation: issue only if fill_o < FIFO_DEPTH, counting the outstanding fetch as occupied. The FIFO never overflows.
- Latency:
  - Pushed byte visible on byte_o with byte_valid_o=1 one cycle after the ack-match edge.
  - After a pop, the next entry appears the following cycle.
- Simultaneous push and pop: fill_o unchanged; ordering preserved. When FIFO is empty, push happens first and the pop is ignored (valid was 0).
- pos_o increments on every pop and wraps at 18 bits. fill_o tracks push/pop exactly.
- rewind_i (any cycle, held any length):
  - FIFO flushed, fetch offset=0, pos_o=0.
  - An in-flight ack is still absorbed (DRAIN); sdram_req_o is never re-toggled before the ack.
  - No pushes occur while rewind_i=1.
- eof_o=1 when any of these hold:
  - loaded_i=0
  - (fetch offset > end_addr_i AND FIFO empty AND no outstanding request)
- end_addr_i changes mid-play: the new value is used on the next IDLE issue decision.
- end_addr_i=0 with loaded_i=1: exactly one byte is delivered.
- Arithmetic: fetch offset is 19 bits, so end_addr_i=18'h3FFFF terminates without wrap. Address = BASE_ADDR + zero-extended offset[17:0].

Decomposition:
- Shared package cas_pkg: CAS_BASE_ADDR constant, offset width (18), FSM state enum {IDLE, WAIT, DRAIN}.
- One sub-module: cas_byte_fifo (synchronous show-ahead FIFO with push, pop, flush, fill count). Fetch FSM and lane select stay in cas_fetch.

Test Plan:
- Load 4-byte image 11 22 33 44, end_addr=3, ack 3 cycles after each req toggle, ready=1 → byte stream 11,22,33,44 in order. Addresses 0x1800000..0x1800003, ds alternates 10/01. Then eof_o=1, pos_o=4.
- ready=0 with end_addr=31 → exactly FIFO_DEPTH (8) fetches issued then the req toggle stops; fill_o=8. Raise ready → fetching resumes, no byte lost or duplicated.
- Assert rewind_i in WAIT, ack arrives 5 cycles later → returned byte not pushed, fill_o=0, next fetch address 0x1800000, next byte_o = image[0].
- loaded_i=0 → sdram_req_o never toggles, eof_o=1. loaded_i=1, end_addr=0 → one byte delivered, then eof_o=1.
- Async reset_n_i low mid-WAIT → all outputs at reset values immediately. Recovery after ack resync: bench aligns ack=0 → stream restarts at offset 0.
- Simultaneous push and pop at fill_o=1 over 100 random-ready cycles → fill_o never exceeds 8. Popped sequence equals image bytes in order (scoreboard check).

Source files
------------

// File: rtl/cas_pkg.sv
// rtl/cas_pkg.sv - shared constants and fetch FSM state type for the CAS prefetcher
package cas_pkg;

   localparam logic [25:0] CAS_BASE_ADDR = 26'h1800000;
   localparam int          CAS_OFS_W     = 18;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DRAIN
   } fetch_state_t;

endpackage

// File: rtl/cas_fetch_if.sv
// rtl/cas_fetch_if.sv - SDRAM toggle-handshake port and tape byte stream interfaces
interface cas_sdram_if;
   logic        sdram_req_o;
   logic        sdram_ack_i;
   logic [25:0] sdram_addr_o;
   logic [1:0]  sdram_ds_o;
   logic [15:0] sdram_q_i;

   modport master (
      output sdram_req_o, sdram_addr_o, sdram_ds_o,
      input  sdram_ack_i, sdram_q_i
   );

   modport slave (
      input  sdram_req_o, sdram_addr_o, sdram_ds_o,
      output sdram_ack_i, sdram_q_i
   );
endinterface

interface cas_byte_if;
   logic [7:0] byte_o;
   logic       byte_valid_o;
   logic       byte_ready_i;

   modport master (
      output byte_o, byte_valid_o,
      input  byte_ready_i
   );

   modport slave (
      input  byte_o, byte_valid_o,
      output byte_ready_i
   );
endinterface

// File: rtl/cas_byte_fifo.sv
// rtl/cas_byte_fifo.sv - show-ahead byte FIFO with push, pop, synchronous flush and fill count
module cas_byte_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [W-1:0]           push_data_i,
   input  logic                   pop_i,
   output logic [W-1:0]           head_o,
   output logic                   valid_o,
   output logic [$clog2(DEPTH):0] fill_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_fill;
   logic          w_push;
   logic          w_pop;

   // Pop is gated by valid, so a pop request against an empty FIFO is ignored.
   assign w_push  = push_i && (r_fill != FULL_C);
   assign w_pop   = pop_i && (r_fill != '0);
   assign valid_o = (r_fill != '0);
   assign head_o  = valid_o ? r_mem[r_rd] : '0;
   assign fill_o  = r_fill;

   always_ff @(posedge clk_i) begin
      if (w_push && !flush_i) begin
         r_mem[r_wr] <= push_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wr   <= '0;
         r_rd   <= '0;
         r_fill <= '0;
      end else if (flush_i) begin
         r_wr   <= '0;
         r_rd   <= '0;
         r_fill <= '0;
      end else begin
         if (w_push) begin
            r_wr <= r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd <= r_rd + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
      end
   end

endmodule

// File: rtl/cas_fetch.sv
// rtl/cas_fetch.sv - sequential CAS byte prefetcher from SDRAM into a show-ahead byte stream
module cas_fetch
   import cas_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [25:0] BASE_ADDR  = CAS_BASE_ADDR
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        rewind_i,
   input  logic                        loaded_i,
   input  logic [CAS_OFS_W-1:0]        end_addr_i,
   cas_sdram_if.master                 sdram,
   cas_byte_if.master                  bstream,
   output logic                        eof_o,
   output logic [$clog2(FIFO_DEPTH):0] fill_o,
   output logic [CAS_OFS_W-1:0]        pos_o
);

   localparam int FW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [FW-1:0] DEPTH_C = FW'(FIFO_DEPTH);

   fetch_state_t         r_state;
   logic                 r_req;
   logic [25:0]          r_addr;
   logic [1:0]           r_ds;
   logic [CAS_OFS_W:0]   r_ofs;
   logic [CAS_OFS_W-1:0] r_pos;

   logic                 w_outstanding;
   logic                 w_in_range;
   logic                 w_issue;
   logic                 w_ack_match;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_valid;
   logic [7:0]           w_lane;
   logic [25:0]          w_next_addr;

   assign w_outstanding = (r_req != sdram.sdram_ack_i);
   // Offset carries one extra bit so end_addr_i = 3FFFF terminates instead of wrapping.
   assign w_in_range    = (r_ofs <= {1'b0, end_addr_i});
   assign w_next_addr   = BASE_ADDR + {8'd0, r_ofs[CAS_OFS_W-1:0]};
   assign w_issue       = (r_state == IDLE) && loaded_i && w_in_range &&
                          (fill_o < DEPTH_C) && !rewind_i && !w_outstanding;
   assign w_ack_match   = (r_state != IDLE) && !w_outstanding;
   assign w_push        = (r_state == WAIT) && w_ack_match && !rewind_i;
   assign w_lane        = r_addr[0] ? sdram.sdram_q_i[7:0] : sdram.sdram_q_i[15:8];
   assign w_pop         = w_valid && bstream.byte_ready_i;

   assign sdram.sdram_req_o  = r_req;
   assign sdram.sdram_addr_o = r_addr;
   assign sdram.sdram_ds_o   = r_ds;
   assign bstream.byte_valid_o = w_valid;
   assign pos_o = r_pos;

   assign eof_o = !loaded_i ||
                  (!w_in_range && (fill_o == '0) && !w_outstanding);

   cas_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (8)
   ) u_fifo (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .flush_i     (rewind_i),
      .push_i      (w_push),
      .push_data_i (w_lane),
      .pop_i       (bstream.byte_ready_i),
      .head_o      (bstream.byte_o),
      .valid_o     (w_valid),
      .fill_o      (fill_o)
   );

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_ds    <= '0;
         r_ofs   <= '0;
         r_pos   <= '0;
      end else begin
         if (rewind_i) begin
            r_ofs <= '0;
            r_pos <= '0;
         end else begin
            if (w_push) begin
               r_ofs <= r_ofs + 1'b1;
            end
            if (w_pop) begin
               r_pos <= r_pos + 1'b1;
            end
         end

         // A rewind during WAIT still waits for the ack so req is never re-toggled early.
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_req   <= ~r_req;
                  r_addr  <= w_next_addr;
                  r_ds    <= {~w_next_addr[0], w_next_addr[0]};
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (w_ack_match) begin
                  r_state <= IDLE;
               end else if (rewind_i) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_ack_match) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cas_fetch.sv
// tb/tb_cas_fetch.sv - self-checking bench for cas_fetch with SDRAM model and byte scoreboard
module tb_cas_fetch;
   import cas_pkg::*;

   localparam int DEPTH = 8;
   localparam logic [25:0] BASE = CAS_BASE_ADDR;

   logic        clk_i      = 1'b0;
   logic        reset_n_i  = 1'b0;
   logic        rewind_i   = 1'b0;
   logic        loaded_i   = 1'b0;
   logic [17:0] end_addr_i = '0;
   logic        eof_o;
   logic [3:0]  fill_o;
   logic [17:0] pos_o;

   cas_sdram_if sd ();
   cas_byte_if  bs ();

   cas_fetch #(
      .FIFO_DEPTH (DEPTH),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .rewind_i   (rewind_i),
      .loaded_i   (loaded_i),
      .end_addr_i (end_addr_i),
      .sdram      (sd),
      .bstream    (bs),
      .eof_o      (eof_o),
      .fill_o     (fill_o),
      .pos_o      (pos_o)
   );

   always #5 clk_i = ~clk_i;

   logic [7:0]  img [64];
   int          lat = 3;
   logic        ack_clear = 1'b1;
   logic        pend = 1'b0;
   int          cnt = 0;
   logic [25:0] m_ofs = '0;

   always @(posedge clk_i) begin
      if (ack_clear) begin
         sd.sdram_ack_i <= 1'b0;
         pend           <= 1'b0;
      end else if (!pend) begin
         if (sd.sdram_req_o != sd.sdram_ack_i) begin
            pend  <= 1'b1;
            cnt   <= lat;
            m_ofs <= sd.sdram_addr_o - BASE;
         end
      end else if (cnt <= 1) begin
         sd.sdram_ack_i <= sd.sdram_req_o;
         sd.sdram_q_i   <= {img[{m_ofs[5:1], 1'b0}], img[{m_ofs[5:1], 1'b1}]};
         pend           <= 1'b0;
      end else begin
         cnt <= cnt - 1;
      end
   end

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  sb [$];
   logic [25:0] alog [$];
   logic [1:0]  dlog [$];
   logic        prev_req = 1'b0;
   int          toggles = 0;
   int          max_fill = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic rdy);
      @(negedge clk_i);
      bs.byte_ready_i = rdy;
      if (sd.sdram_req_o !== prev_req) begin
         toggles++;
         alog.push_back(sd.sdram_addr_o);
         dlog.push_back(sd.sdram_ds_o);
         prev_req = sd.sdram_req_o;
      end
      if (int'(fill_o) > max_fill) max_fill = int'(fill_o);
      if (bs.byte_valid_o && rdy) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL pop_unexpected: observed byte %0h expected none", bs.byte_o);
         end else begin
            chk("pop_byte", {24'd0, bs.byte_o}, {24'd0, sb.pop_front()});
         end
      end
   endtask

   task automatic run_until_eof(input int budget);
      int n = 0;
      do begin
         tick(1'b1);
         n++;
      end while (!(eof_o && sb.size() == 0) && n < budget);
      chk("eof_reached", {31'd0, eof_o}, 32'd1);
      chk("sb_drained", sb.size(), 32'd0);
   endtask

   task automatic rewind_pulse();
      rewind_i = 1'b1;
      tick(1'b0);
      tick(1'b0);
      rewind_i = 1'b0;
      sb.delete();
   endtask

   task automatic push_image(input int last);
      for (int i = 0; i <= last; i++) sb.push_back(img[i]);
   endtask

   initial begin
      int n;
      bs.byte_ready_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst_req", {31'd0, sd.sdram_req_o}, 32'd0);
      chk("rst_valid", {31'd0, bs.byte_valid_o}, 32'd0);
      chk("rst_fill", {28'd0, fill_o}, 32'd0);
      chk("rst_byte", {24'd0, bs.byte_o}, 32'd0);
      chk("rst_pos", {14'd0, pos_o}, 32'd0);
      chk("rst_eof_unloaded", {31'd0, eof_o}, 32'd1);

      img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
      loaded_i = 1'b1;
      end_addr_i = 18'd3;
      #1;
      chk("rst_eof_loaded", {31'd0, eof_o}, 32'd0);

      // four-byte image streamed with ready held high
      @(negedge clk_i);
      reset_n_i = 1'b1;
      ack_clear = 1'b0;
      lat = 3;
      push_image(3);
      run_until_eof(200);
      chk("t1_pos", {14'd0, pos_o}, 32'd4);
      chk("t1_toggles", toggles, 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_addr", {6'd0, alog[i]}, {6'd0, BASE + 26'(i)});
         chk("t1_ds", {30'd0, dlog[i]}, (i % 2 == 0) ? 32'd2 : 32'd1);
      end

      // back-pressure: fetching stops with exactly DEPTH slots reserved
      for (int i = 0; i < 32; i++) img[i] = 8'(i * 7 + 3);
      end_addr_i = 18'd31;
      lat = 2;
      rewind_pulse();
      toggles = 0;
      push_image(31);
      repeat (80) tick(1'b0);
      chk("t2_toggles_full", toggles, 32'd8);
      chk("t2_fill_full", {28'd0, fill_o}, 32'd8);
      run_until_eof(600);
      chk("t2_pos", {14'd0, pos_o}, 32'd32);
      chk("t2_toggles", toggles, 32'd32);

      // rewind while a fetch is in flight
      lat = 6;
      rewind_pulse();
      toggles = 0;
      n = 0;
      while (toggles < 1 && n < 20) begin tick(1'b0); n++; end
      chk("t3_issued", toggles, 32'd1);
      rewind_i = 1'b1;
      n = 0;
      while (sd.sdram_req_o !== sd.sdram_ack_i && n < 30) begin tick(1'b0); n++; end
      tick(1'b0);
      tick(1'b0);
      chk("t3_fill_after_drain", {28'd0, fill_o}, 32'd0);
      chk("t3_valid_after_drain", {31'd0, bs.byte_valid_o}, 32'd0);
      chk("t3_no_retoggle", toggles, 32'd1);
      rewind_i = 1'b0;
      alog.delete();
      dlog.delete();
      toggles = 0;
      push_image(31);
      run_until_eof(800);
      chk("t3_restart_addr", {6'd0, alog[0]}, {6'd0, BASE});
      chk("t3_toggles", toggles, 32'd32);

      // unloaded image never fetches; single-byte image
      loaded_i = 1'b0;
      rewind_pulse();
      toggles = 0;
      repeat (20) tick(1'b0);
      chk("t4_no_fetch", toggles, 32'd0);
      chk("t4_eof_unloaded", {31'd0, eof_o}, 32'd1);
      end_addr_i = 18'd0;
      img[0] = 8'hA5;
      loaded_i = 1'b1;
      sb.push_back(img[0]);
      run_until_eof(100);
      chk("t4_one_fetch", toggles, 32'd1);
      chk("t4_pos", {14'd0, pos_o}, 32'd1);

      // async reset in the middle of a fetch
      for (int i = 0; i < 32; i++) img[i] = 8'(255 - i * 3);
      end_addr_i = 18'd31;
      lat = 10;
      rewind_pulse();
      push_image(31);
      toggles = 0;
      n = 0;
      while (toggles < 3 && n < 100) begin tick(1'b0); n++; end
      tick(1'b1);
      tick(1'b0);
      #2;
      reset_n_i = 1'b0;
      ack_clear = 1'b1;
      #1;
      chk("t5_req", {31'd0, sd.sdram_req_o}, 32'd0);
      chk("t5_valid", {31'd0, bs.byte_valid_o}, 32'd0);
      chk("t5_fill", {28'd0, fill_o}, 32'd0);
      chk("t5_pos", {14'd0, pos_o}, 32'd0);
      chk("t5_byte", {24'd0, bs.byte_o}, 32'd0);
      repeat (2) @(negedge clk_i);
      prev_req = 1'b0;
      sb.delete();
      alog.delete();
      dlog.delete();
      toggles = 0;
      lat = 3;
      reset_n_i = 1'b1;
      ack_clear = 1'b0;
      push_image(31);
      run_until_eof(800);
      chk("t5_restart_addr", {6'd0, alog[0]}, {6'd0, BASE});
      chk("t5_pos_end", {14'd0, pos_o}, 32'd32);

      // random consumer back-pressure with a fast SDRAM
      for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
      lat = 1;
      rewind_pulse();
      push_image(31);
      max_fill = 0;
      repeat (100) tick(1'($urandom_range(0, 1)));
      run_until_eof(600);
      chk("t6_fill_bound", {31'd0, max_fill <= DEPTH}, 32'd1);
      chk("t6_pos", {14'd0, pos_o}, 32'd32);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
